// File: rtl/divisor_secuencial_8_4_if.sv
// Start/done bundle for divisor_secuencial_8_4; the master issues divisions, the slave is the divider.
// Handshake: Inicio is honoured only while Ocupado=0; Listo pulses for one cycle when the
// results are valid, and they stay valid until the next accepted Inicio completes.
interface divisor_secuencial_8_4_if #(
    parameter int ANCHO_DIVIDENDO = 8,
    parameter int ANCHO_DIVISOR   = 4
);
    logic                       Inicio;
    logic [ANCHO_DIVIDENDO-1:0] Dividendo;
    logic [ANCHO_DIVISOR-1:0]   Divisor;
    logic [ANCHO_DIVIDENDO-1:0] Cociente;
    logic [ANCHO_DIVISOR-1:0]   Residuo;
    logic                       Ocupado;
    logic                       Listo;
    logic                       ErrorDiv0;
    logic                       ChequeoOk;

    modport master (
        output Inicio, Dividendo, Divisor,
        input  Cociente, Residuo, Ocupado, Listo, ErrorDiv0, ChequeoOk
    );

    modport slave (
        input  Inicio, Dividendo, Divisor,
        output Cociente, Residuo, Ocupado, Listo, ErrorDiv0, ChequeoOk
    );
endinterface

// File: rtl/divisor_secuencial_8_4.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional macro DIVISOR_AUTOCHEQUEO_EN adds a Cociente*Divisor+Residuo round-trip check.
module divisor_secuencial_8_4 #(
    parameter int ANCHO_DIVIDENDO = 8,
    parameter int ANCHO_DIVISOR   = 4
) (
    input  logic                    Reloj,
    input  logic                    Reinicio_n,
    divisor_secuencial_8_4_if.slave bus,
    output logic [1:0]              estado
);
    localparam int AC = $clog2(ANCHO_DIVIDENDO + 1);
    localparam int AD = ANCHO_DIVIDENDO;
    localparam int AS = ANCHO_DIVISOR;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        DIVIDE = 2'd1,
        FIN    = 2'd2
    } estado_t;

    estado_t estado_q, estado_d;
    logic    cargar, cargar_cero, iterar, terminar;

    logic [AD-1:0] cociente_sr;
    logic [AS-1:0] divisor_q;
    logic [AS:0]   parcial;
    logic [AC-1:0] contador;
    logic          div_cero;

    logic [AS:0]   desplazado;
    logic [AS+1:0] resta;
    logic          prestamo;

    always_ff @(posedge Reloj or negedge Reinicio_n) begin
        if (!Reinicio_n) begin
            estado_q <= REPOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        cargar      = 1'b0;
        cargar_cero = 1'b0;
        iterar      = 1'b0;
        terminar    = 1'b0;
        unique case (estado_q)
            REPOSO: begin
                if (bus.Inicio) begin
                    if (bus.Divisor != '0) begin
                        cargar   = 1'b1;
                        estado_d = DIVIDE;
                    end else begin
                        cargar_cero = 1'b1;
                        estado_d    = FIN;
                    end
                end
            end
            DIVIDE: begin
                iterar = 1'b1;
                if (contador == AC'(1)) begin
                    estado_d = FIN;
                end
            end
            FIN: begin
                terminar = 1'b1;
                estado_d = REPOSO;
            end
            default: estado_d = REPOSO;
        endcase
    end

    // The partial remainder stays below the divisor, so after the shift it fits in AS+1 bits.
    assign desplazado = {parcial[AS-1:0], cociente_sr[AD-1]};
    assign resta      = {1'b0, desplazado} - {2'b00, divisor_q};
    assign prestamo   = resta[AS+1];

    always_ff @(posedge Reloj or negedge Reinicio_n) begin
        if (!Reinicio_n) begin
            cociente_sr <= '0;
            divisor_q   <= '0;
            parcial     <= '0;
            contador    <= '0;
            div_cero    <= 1'b0;
        end else if (cargar) begin
            cociente_sr <= bus.Dividendo;
            divisor_q   <= bus.Divisor;
            parcial     <= '0;
            contador    <= AC'(AD);
            div_cero    <= 1'b0;
        end else if (cargar_cero) begin
            div_cero <= 1'b1;
        end else if (iterar) begin
            contador <= contador - AC'(1);
            if (prestamo) begin
                parcial     <= desplazado;
                cociente_sr <= {cociente_sr[AD-2:0], 1'b0};
            end else begin
                parcial     <= resta[AS:0];
                cociente_sr <= {cociente_sr[AD-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge Reloj or negedge Reinicio_n) begin
        if (!Reinicio_n) begin
            bus.Cociente  <= '0;
            bus.Residuo   <= '0;
            bus.Listo     <= 1'b0;
            bus.ErrorDiv0 <= 1'b0;
        end else begin
            bus.Listo <= terminar;
            if (cargar) begin
                bus.ErrorDiv0 <= 1'b0;
            end
            if (terminar) begin
                bus.Cociente  <= div_cero ? '1 : cociente_sr;
                bus.Residuo   <= div_cero ? '0 : parcial[AS-1:0];
                bus.ErrorDiv0 <= div_cero;
            end
        end
    end

`ifdef DIVISOR_AUTOCHEQUEO_EN
    localparam int AP = AD + AS;

    logic [AD-1:0] dividendo_cap;
    logic [AP-1:0] reconstruido;
    logic          chequeo_q;

    assign reconstruido = AP'(cociente_sr) * AP'(divisor_q) + AP'(parcial[AS-1:0]);

    always_ff @(posedge Reloj or negedge Reinicio_n) begin
        if (!Reinicio_n) begin
            dividendo_cap <= '0;
            chequeo_q     <= 1'b1;
        end else begin
            if (cargar) begin
                dividendo_cap <= bus.Dividendo;
            end
            if (terminar) begin
                chequeo_q <= div_cero | (reconstruido == AP'(dividendo_cap));
            end
        end
    end

    assign bus.ChequeoOk = chequeo_q;
`else
    assign bus.ChequeoOk = 1'b1;
`endif

    assign bus.Ocupado = (estado_q != REPOSO);
    assign estado      = estado_q;
endmodule

// File: tb/tb_divisor_secuencial_8_4.sv
// Scoreboard bench for divisor_secuencial_8_4: directed vectors, reset abort, ignored restart
// and a full sweep of nonzero divisors against the language's own / and %.
module tb_divisor_secuencial_8_4;
    localparam int W = 14;

    logic       Reloj;
    logic       Reinicio_n;
    logic [1:0] estado;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    divisor_secuencial_8_4_if bus ();

    divisor_secuencial_8_4 dut (
        .Reloj      (Reloj),
        .Reinicio_n (Reinicio_n),
        .bus        (bus),
        .estado     (estado)
    );

    // clock / reset
    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic comprobar(input string nombre, input int actual, input int requerido);
        checks++;
        if (actual != requerido) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nombre, actual, requerido, $time);
        end
    endtask

    // monitor: expected layout {ErrorDiv0, ChequeoOk, Cociente, Residuo}
    always @(negedge Reloj) begin
        logic [W-1:0] esperado;
        if (Reinicio_n && bus.Listo) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL listo_inesperado: got Listo=1, required no pending result (t=%0t)", $time);
            end else begin
                esperado = exp_q.pop_front();
                comprobar("cociente",  int'(bus.Cociente),  int'(esperado[11:4]));
                comprobar("residuo",   int'(bus.Residuo),   int'(esperado[3:0]));
                comprobar("error_div0", int'(bus.ErrorDiv0), int'(esperado[13]));
                comprobar("chequeo_ok", int'(bus.ChequeoOk), int'(esperado[12]));
            end
        end
    end

    // driver: call on a negedge; returns on the negedge where Listo is seen
    task automatic ejecutar(input logic [7:0] dvd, input logic [3:0] dvs,
                            input logic [7:0] ec, input logic [3:0] er, input logic ee,
                            input int lat, input int pulso_en);
        int   n;
        logic hecho;
        exp_q.push_back({ee, 1'b1, ec, er});
        bus.Inicio    = 1'b1;
        bus.Dividendo = dvd;
        bus.Divisor   = dvs;
        @(posedge Reloj);
        #1;
        bus.Inicio    = 1'b0;
        bus.Dividendo = 8'($urandom_range(0, 255));
        bus.Divisor   = 4'($urandom_range(0, 15));
        n     = 0;
        hecho = 1'b0;
        while (!hecho && n < 30) begin
            @(negedge Reloj);
            n++;
            if (n == 1) comprobar("ocupado_tras_aceptar", int'(bus.Ocupado), 1);
            if (bus.Listo) begin
                hecho = 1'b1;
            end else if (n == pulso_en) begin
                bus.Inicio    = 1'b1;
                bus.Dividendo = 8'd50;
                bus.Divisor   = 4'd5;
            end else begin
                bus.Inicio = 1'b0;
            end
        end
        bus.Inicio = 1'b0;
        if (!hecho) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no Listo within 30 cycles, required Listo after %0d edges", lat);
        end else begin
            comprobar("latencia", n - 1, lat);
            comprobar("ocupado_con_listo", int'(bus.Ocupado), 0);
        end
    endtask

    initial begin
        Reinicio_n    = 1'b0;
        bus.Inicio    = 1'b0;
        bus.Dividendo = '0;
        bus.Divisor   = '0;
        repeat (2) @(negedge Reloj);
        comprobar("rst_cociente", int'(bus.Cociente), 0);
        comprobar("rst_residuo",  int'(bus.Residuo), 0);
        comprobar("rst_ocupado",  int'(bus.Ocupado), 0);
        comprobar("rst_listo",    int'(bus.Listo), 0);
        comprobar("rst_error",    int'(bus.ErrorDiv0), 0);
        comprobar("rst_chequeo",  int'(bus.ChequeoOk), 1);
        comprobar("rst_estado",   int'(estado), 0);
        Reinicio_n = 1'b1;
        @(negedge Reloj);

        ejecutar(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9, 0);
        @(negedge Reloj);

        // back to back: next start issued on the Listo cycle
        ejecutar(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 9, 0);
        ejecutar(8'd15,  4'd15, 8'd1,   4'd0, 1'b0, 9, 0);
        ejecutar(8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 9, 0);
        @(negedge Reloj);

        ejecutar(8'd100, 4'd0, 8'hFF, 4'd0, 1'b1, 1, 0);
        ejecutar(8'd9,   4'd3, 8'd3,  4'd0, 1'b0, 9, 0);
        @(negedge Reloj);

        // restart attempt mid-operation must be ignored
        ejecutar(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9, 4);
        repeat (12) @(negedge Reloj);

        // reset mid-operation aborts without Listo
        bus.Inicio    = 1'b1;
        bus.Dividendo = 8'd200;
        bus.Divisor   = 4'd7;
        @(posedge Reloj);
        #1;
        bus.Inicio = 1'b0;
        repeat (5) @(negedge Reloj);
        Reinicio_n = 1'b0;
        #1;
        comprobar("abort_cociente", int'(bus.Cociente), 0);
        comprobar("abort_residuo",  int'(bus.Residuo), 0);
        comprobar("abort_ocupado",  int'(bus.Ocupado), 0);
        comprobar("abort_listo",    int'(bus.Listo), 0);
        comprobar("abort_error",    int'(bus.ErrorDiv0), 0);
        comprobar("abort_chequeo",  int'(bus.ChequeoOk), 1);
        repeat (3) @(negedge Reloj);
        Reinicio_n = 1'b1;
        repeat (12) @(negedge Reloj);
        ejecutar(8'd77, 4'd6, 8'd12, 4'd5, 1'b0, 9, 0);
        @(negedge Reloj);

        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                ejecutar(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 9, 0);
            end
        end

        repeat (12) @(negedge Reloj);
        comprobar("cola_vacia", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
